// File: rtl/sgtl5000_config_seq.sv
// SGTL5000 configuration sequencer.
// Walks an external (address, data) table through a single I2C register-write
// engine after start, then serialises runtime user writes onto the same engine.
module sgtl5000_config_seq #(
    parameter int NUM_WRITES   = 8,
    parameter int IDX_W        = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             clk50_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    output logic [IDX_W-1:0] rom_index_o,
    input  logic [15:0]      rom_addr_i,
    input  logic [15:0]      rom_data_i,
    input  logic             user_req_i,
    input  logic [15:0]      user_addr_i,
    input  logic [15:0]      user_data_i,
    output logic             user_grant_o,
    output logic [15:0]      i2c_addr_o,
    output logic [15:0]      i2c_data_o,
    output logic             i2c_enable_o,
    input  logic             i2c_ack_i,
    output logic             init_done_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [7:0]       write_count_o
);

    // One shared counter times both the busy-start timeout and the post-write gap.
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_READY,
        S_ERROR
    } state_t;

    typedef enum logic {
        SRC_ROM,
        SRC_USER
    } src_t;

    state_t           state_q;
    src_t             src_q;
    logic [IDX_W-1:0] rom_index_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      i2c_addr_q;
    logic [15:0]      i2c_data_q;
    logic             user_grant_q;
    logic             init_done_q;
    logic             busy_q;
    logic             error_q;
    logic [7:0]       write_count_q;

    // Sequencer FSM: all outputs except the engine enable are registered here.
    always_ff @(posedge clk50_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            src_q         <= SRC_ROM;
            rom_index_q   <= '0;
            cnt_q         <= '0;
            i2c_addr_q    <= '0;
            i2c_data_q    <= '0;
            user_grant_q  <= 1'b0;
            init_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            write_count_q <= '0;
        end else begin
            user_grant_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rom_index_q <= '0;
                        src_q       <= SRC_ROM;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i2c_addr_q <= rom_addr_i;
                    i2c_data_q <= rom_data_i;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Engine must be idle before it can accept the enable.
                    if (i2c_ack_i) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!i2c_ack_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        init_done_q <= 1'b0;
                        state_q     <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    // No timeout: the first write carries the codec power-up delay.
                    if (i2c_ack_i) begin
                        write_count_q <= write_count_q + 8'd1;
                        cnt_q         <= '0;
                        state_q       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        if (src_q == SRC_ROM && rom_index_q != IDX_W'(NUM_WRITES - 1)) begin
                            rom_index_q <= rom_index_q + IDX_W'(1);
                            state_q     <= S_LOAD;
                        end else begin
                            if (src_q == SRC_ROM) begin
                                init_done_q <= 1'b1;
                            end
                            busy_q  <= 1'b0;
                            state_q <= S_READY;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_READY: begin
                    // A restart takes priority over a pending user write.
                    if (start_i) begin
                        init_done_q <= 1'b0;
                        rom_index_q <= '0;
                        src_q       <= SRC_ROM;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end else if (user_req_i) begin
                        user_grant_q <= 1'b1;
                        i2c_addr_q   <= user_addr_i;
                        i2c_data_q   <= user_data_i;
                        src_q        <= SRC_USER;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ERROR: begin
                    if (start_i) begin
                        error_q     <= 1'b0;
                        rom_index_q <= '0;
                        src_q       <= SRC_ROM;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Enable is decoded straight from the state so reset drops it immediately.
    always_comb begin
        i2c_enable_o = (state_q == S_ISSUE);
    end

    assign rom_index_o   = rom_index_q;
    assign user_grant_o  = user_grant_q;
    assign i2c_addr_o    = i2c_addr_q;
    assign i2c_data_o    = i2c_data_q;
    assign init_done_o   = init_done_q;
    assign busy_o        = busy_q;
    assign error_o       = error_q;
    assign write_count_o = write_count_q;

endmodule

// File: tb/tb_sgtl5000_config_seq.sv
// Directed bench for sgtl5000_config_seq with a behavioural I2C engine model.
module tb_sgtl5000_config_seq;

    localparam int NW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] rom_index;
    logic [15:0]   rom_addr;
    logic [15:0]   rom_data;
    logic          user_req;
    logic [15:0]   user_addr;
    logic [15:0]   user_data;
    logic          user_grant;
    logic [15:0]   i2c_addr;
    logic [15:0]   i2c_data;
    logic          i2c_en;
    logic          ack = 1'b1;
    logic          init_done;
    logic          busy;
    logic          err;
    logic [7:0]    wcnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] tbl_a [0:3] = '{16'h0030, 16'h0022, 16'h0002, 16'h0000};
    logic [15:0] tbl_d [0:3] = '{16'h4060, 16'h0000, 16'h0073, 16'h0000};

    assign rom_addr = tbl_a[rom_index];
    assign rom_data = tbl_d[rom_index];

    always #10 clk = ~clk;

    sgtl5000_config_seq #(
        .NUM_WRITES  (NW),
        .IDX_W       (IW),
        .GAP_CYCLES  (4),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk50_i      (clk),
        .reset_n_i    (rst_n),
        .start_i      (start),
        .rom_index_o  (rom_index),
        .rom_addr_i   (rom_addr),
        .rom_data_i   (rom_data),
        .user_req_i   (user_req),
        .user_addr_i  (user_addr),
        .user_data_i  (user_data),
        .user_grant_o (user_grant),
        .i2c_addr_o   (i2c_addr),
        .i2c_data_o   (i2c_data),
        .i2c_enable_o (i2c_en),
        .i2c_ack_i    (ack),
        .init_done_o  (init_done),
        .busy_o       (busy),
        .error_o      (err),
        .write_count_o(wcnt)
    );

    // Engine model: drops ack the cycle after sampling enable, busy for 20 cycles.
    logic        dead = 1'b0;
    int          eng_cnt = 0;
    int          unstable = 0;
    logic [15:0] cap_a = '0;
    logic [15:0] cap_d = '0;
    logic [15:0] log_a [$];
    logic [15:0] log_d [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            ack     <= 1'b1;
            eng_cnt <= 0;
        end else if (ack) begin
            if (i2c_en && !dead) begin
                ack     <= 1'b0;
                eng_cnt <= 20;
                cap_a   <= i2c_addr;
                cap_d   <= i2c_data;
                log_a.push_back(i2c_addr);
                log_d.push_back(i2c_data);
                $display("txn %0d addr=%04h data=%04h", log_a.size(), i2c_addr, i2c_data);
            end
        end else begin
            if (i2c_addr !== cap_a || i2c_data !== cap_d) unstable <= unstable + 1;
            if (eng_cnt == 1) ack <= 1'b1;
            eng_cnt <= eng_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for busy to fall; returns the number of negedges waited.
    task automatic wait_idle(input string tag, output int n);
        n = 1;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic check_table(input string tag, input int base);
        for (int i = 0; i < NW; i++) begin
            chk({tag, "_a"}, 32'(log_a[base + i]), 32'(tbl_a[i]));
            chk({tag, "_d"}, 32'(log_d[base + i]), 32'(tbl_d[i]));
        end
    endtask

    task automatic user_write(input logic [15:0] a, input logic [15:0] d);
        int n;
        int w;
        user_req  = 1'b1;
        user_addr = a;
        user_data = d;
        n = 0;
        @(negedge clk);
        while (!user_grant && n < 50) begin
            @(negedge clk);
            n++;
        end
        user_req = 1'b0;
        chk("uw_grant", 32'(user_grant), 1);
        wait_idle("uw", w);
        chk("uw_addr", 32'(log_a[log_a.size() - 1]), 32'(a));
        chk("uw_data", 32'(log_d[log_d.size() - 1]), 32'(d));
    endtask

    initial begin
        int n;
        int base;
        int grants;
        int busys;

        rst_n = 1'b1; start = 1'b0; user_req = 1'b0; user_addr = '0; user_data = '0;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idx",   32'(rom_index), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_done",  32'(init_done), 0);
        chk("rst_wcnt",  32'(wcnt), 0);
        chk("rst_en",    32'(i2c_en), 0);
        chk("rst_addr",  32'(i2c_addr), 0);
        chk("rst_data",  32'(i2c_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table run from IDLE
        pulse_start();
        chk("load_busy", 32'(busy), 1);
        chk("load_en",   32'(i2c_en), 0);
        chk("load_idx",  32'(rom_index), 0);
        @(negedge clk);
        chk("issue_en",  32'(i2c_en), 1);
        chk("issue_done", 32'(init_done), 0);
        @(negedge clk);
        chk("wb_en",     32'(i2c_en), 0);
        wait_idle("init1", n);
        chk("init_cycles", n, 79);
        chk("init_done1", 32'(init_done), 1);
        chk("init_logn",  log_a.size(), 3);
        check_table("init1", 0);
        chk("init_wcnt",  32'(wcnt), 3);
        chk("init_idx",   32'(rom_index), 2);

        // Runtime user write
        user_req = 1'b1; user_addr = 16'h0020; user_data = 16'h003C;
        @(negedge clk);
        chk("ug_pulse", 32'(user_grant), 1);
        chk("ug_issue", 32'(i2c_en), 1);
        user_req = 1'b0;
        @(negedge clk);
        chk("ug_once",  32'(user_grant), 0);
        wait_idle("user1", n);
        chk("user_logn", log_a.size(), 4);
        chk("user_a",    32'(log_a[3]), 32'h0020);
        chk("user_d",    32'(log_d[3]), 32'h003C);
        chk("user_wcnt", 32'(wcnt), 4);
        chk("user_done", 32'(init_done), 1);

        // start beats user_req in READY
        start = 1'b1; user_req = 1'b1; user_addr = 16'h1234; user_data = 16'h5678;
        @(negedge clk);
        start = 1'b0; user_req = 1'b0;
        chk("pri_grant", 32'(user_grant), 0);
        chk("pri_done",  32'(init_done), 0);
        chk("pri_idx",   32'(rom_index), 0);
        chk("pri_busy",  32'(busy), 1);
        wait_idle("rerun", n);
        chk("rerun_logn", log_a.size(), 7);
        check_table("rerun", 4);
        chk("rerun_wcnt", 32'(wcnt), 7);

        // Engine never starts -> timeout into ERROR
        dead = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("to_early", 32'(err), 0);
        @(negedge clk);
        chk("to_err",  32'(err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_done", 32'(init_done), 0);
        chk("to_en",   32'(i2c_en), 0);
        dead = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_hold", 32'(err), 1);
        pulse_start();
        chk("err_clr",  32'(err), 0);
        chk("err_idx",  32'(rom_index), 0);
        chk("err_busy", 32'(busy), 1);
        wait_idle("errrun", n);
        check_table("errrun", 7);
        chk("err_wcnt", 32'(wcnt), 10);

        // Reset during WAIT_DONE of write 2
        base = log_a.size();
        pulse_start();
        n = 0;
        while (log_a.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rs_reach", log_a.size(), base + 2);
        repeat (5) @(negedge clk);
        chk("rs_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_en",   32'(i2c_en), 0);
        chk("rs_addr", 32'(i2c_addr), 0);
        chk("rs_data", 32'(i2c_data), 0);
        chk("rs_wcnt", 32'(wcnt), 0);
        chk("rs_idx",  32'(rom_index), 0);
        chk("rs_misc", {29'd0, init_done, err, user_grant}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        user_req = 1'b1; user_addr = 16'h00AA; user_data = 16'h00BB;
        grants = 0; busys = 0;
        repeat (6) begin
            @(negedge clk);
            if (user_grant) grants++;
            if (busy) busys++;
        end
        user_req = 1'b0;
        chk("rs_nogrant", grants, 0);
        chk("rs_nobusy",  busys, 0);
        pulse_start();
        wait_idle("rsrun", n);
        check_table("rsrun", log_a.size() - NW);
        chk("rs_wcnt3", 32'(wcnt), 3);
        chk("rs_done",  32'(init_done), 1);

        // 256 runtime writes -> counter wraps back to 3
        for (int i = 0; i < 256; i++) begin
            user_write(16'h0100 + 16'(i), 16'(i * 3) ^ 16'hA5A5);
        end
        chk("wrap_wcnt",  32'(wcnt), 3);
        chk("wrap_done",  32'(init_done), 1);
        chk("stable",     unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sgtl5000_config_seq.md
# sgtl5000_config_seq

Sequencer that owns the single I2C register-write engine feeding the SGTL5000 codec. On `start` it walks an external table of NUM_WRITES (register address, data) pairs and issues one write per entry through the I2C engine's enable/acknowledge handshake. After the table completes it arbitrates runtime write requests (volume, mute, routing) from a single user port onto the same engine. It sits between the top-level control logic and the I2C interface block.

## Interface
- NUM_WRITES, 8: table entries per init run; must be >= 1.
- IDX_W, $clog2(NUM_WRITES) (minimum 1): width of `rom_index`.
- GAP_CYCLES, 16: idle cycles inserted after every completed write.
- BUSY_TIMEOUT, 4: cycles allowed for `i2c_ack` to fall after enable before declaring error.
- clk50  in  1  50 MHz system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin (or restart) init sequence; sampled only in IDLE, READY, ERROR.
- rom_index  out  IDX_W  table entry currently being loaded.
- rom_addr  in  16  register address for `rom_index`; combinational lookup, valid the same cycle.
- rom_data  in  16  register data for `rom_index`; same timing as `rom_addr`.
- user_req  in  1  runtime write request; held high until granted.
- user_addr  in  16  runtime register address; sampled on grant.
- user_data  in  16  runtime register data; sampled on grant.
- user_grant  out  1  one-cycle pulse: user request accepted this cycle.
- i2c_addr  out  16  register address to I2C engine; registered, held for whole transaction.
- i2c_data  out  16  register data to I2C engine; registered, held for whole transaction.
- i2c_enable  out  1  write request to I2C engine.
- i2c_ack  in  1  I2C engine idle (high in its reset state, low while busy).
- init_done  out  1  table completed; runtime writes allowed.
- busy  out  1  transaction in progress.
- error  out  1  I2C engine failed to start a write.
- write_count  out  8  completed writes since reset; wraps 255 -> 0.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, READY, ERROR. The source flag is ROM or USER.
- Reset (async) puts the block in IDLE with every output 0, `rom_index` 0, source ROM, and counters 0.
- IDLE: `start` sets `rom_index` to 0 and source to ROM, then goes to LOAD. `user_req` is ignored and `user_grant` stays 0.
- LOAD: `i2c_addr` <= `rom_addr` and `i2c_data` <= `rom_data`, then go to ISSUE.
- ISSUE: `i2c_enable` = 1 (combinational, state == ISSUE). Go to WAIT_BUSY when `i2c_ack` = 1. Otherwise stay in ISSUE with enable held.
- WAIT_BUSY: go to WAIT_DONE on `i2c_ack` = 0. Count cycles; if `i2c_ack` is still 1 after BUSY_TIMEOUT cycles, go to ERROR.
- WAIT_DONE: go to GAP on `i2c_ack` = 1. There is no timeout, because the engine's first write includes a ~2.4 ms power-up delay. `write_count` increments on this transition.
- GAP: wait GAP_CYCLES cycles, then:
  - source ROM and `rom_index` < NUM_WRITES-1: increment `rom_index`, go to LOAD.
  - source ROM and `rom_index` = NUM_WRITES-1: set `init_done`, go to READY.
  - source USER: go to READY.
- READY:
  - `start` = 1: clear `init_done`, set `rom_index` to 0 and source to ROM, go to LOAD. `start` wins over a simultaneous `user_req`, and `user_grant` stays 0.
  - else `user_req` = 1: pulse `user_grant`, latch `user_addr`/`user_data` into `i2c_addr`/`i2c_data`, set source to USER, go to ISSUE.
- ERROR: `error` = 1, `busy` = 0, `init_done` = 0. Remains in ERROR until `start`, which clears `error` and reruns the table from index 0.
- `busy` = 1 in LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP. `start` and `user_req` are ignored while busy.
- `i2c_addr`/`i2c_data` change only in LOAD or on grant. The engine builds its shift word combinationally from them, so they must stay stable until WAIT_DONE exits.

## Timing
- Outputs other than `i2c_enable` are registered.
- `start` high at edge N: LOAD in cycle N+1, ISSUE (`i2c_enable` high) in N+2, WAIT_BUSY in N+3.
- Grant at edge N: ISSUE in cycle N+1.
- Against an engine that drops `i2c_ack` the cycle after it samples enable: ISSUE lasts 1 cycle and WAIT_BUSY lasts 1 cycle.
- Per-write overhead beyond the engine's busy time: LOAD 1 + ISSUE 1 + WAIT_BUSY 1 + GAP_CYCLES.
- Asserting `reset_n` mid-transaction forces IDLE immediately and drops `i2c_enable`. The engine is reset separately by the top level.

## Test plan
Parameters for all scenarios: NUM_WRITES=3, GAP_CYCLES=4, BUSY_TIMEOUT=4. The bench uses a behavioural engine model that drops `i2c_ack` one cycle after enable and stays busy for 20 cycles.
- Table {0x0030:0x4060, 0x0022:0x0000, 0x0002:0x0073}, `start` pulse -> three enable pulses carrying exactly these pairs in order. `init_done` rises after the third GAP, and `write_count` = 3.
- In READY, `user_req` with 0x0020:0x003C -> `user_grant` for exactly 1 cycle, one transaction with 0x0020:0x003C, return to READY, `write_count` = 4.
- `start` and `user_req` high in the same READY cycle -> no grant, `init_done` drops, `rom_index` = 0, and the table reruns.
- Engine model that never drops `i2c_ack` -> after 4 cycles in WAIT_BUSY: `error` = 1, `busy` = 0. A subsequent `start` clears `error` and restarts at index 0.
- `reset_n` low during WAIT_DONE of write 2 -> all outputs 0 in the same cycle, state IDLE, and `user_req` is ignored afterwards until `start`.
- 256 user writes after init -> `write_count` wraps to 3 (3 + 256 mod 256). Throughout, `i2c_addr`/`i2c_data` hold stable during every WAIT_DONE.
